// File: rtl/exception_vector_fetch.sv
// Exception vector fetch sequencer.
// Accepts one exception request and captures its EPC and cause. It then reads
// the cause's vector byte from memory and latches it for the extension unit.
// Finally it issues a single PC load strobe with the vector select asserted.
module exception_vector_fetch #(
  parameter int         MEM_LATENCY   = 1,
  parameter logic [7:0] ADDR_OPCODE   = 8'd253,
  parameter logic [7:0] ADDR_OVERFLOW = 8'd254,
  parameter logic [7:0] ADDR_DIVZERO  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] epc_in,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [7:0]  vector_byte,
  output logic        sel_vector,
  output logic        pc_write,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    REDIRECT
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mem_addr_q;
  logic        mem_read_q;
  logic [31:0] epc_q;
  logic [1:0]  cause_q;
  logic [7:0]  vector_byte_q;
  logic        sel_vector_q;
  logic        pc_write_q;
  logic        busy_q;

  logic        req_any;
  logic [1:0]  cause_d;
  logic [7:0]  addr_d;

  // Priority encode the pending request: opcode > overflow > divzero
  always_comb begin
    req_any = exc_opcode | exc_overflow | exc_divzero;
    cause_d = 2'b00;
    addr_d  = '0;
    if (exc_opcode) begin
      cause_d = 2'b01;
      addr_d  = ADDR_OPCODE;
    end else if (exc_overflow) begin
      cause_d = 2'b10;
      addr_d  = ADDR_OVERFLOW;
    end else if (exc_divzero) begin
      cause_d = 2'b11;
      addr_d  = ADDR_DIVZERO;
    end
  end

  // Sequencer FSM with registered Moore outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_read_q    <= 1'b0;
      epc_q         <= '0;
      cause_q       <= '0;
      vector_byte_q <= '0;
      sel_vector_q  <= 1'b0;
      pc_write_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            epc_q      <= epc_in;
            cause_q    <= cause_d;
            mem_addr_q <= {24'b0, addr_d};
            cnt_q      <= 4'(MEM_LATENCY - 1);
            mem_read_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= READ;
          end
        end
        READ: begin
          if (cnt_q == '0) begin
            vector_byte_q <= mem_rdata;
            mem_read_q    <= 1'b0;
            pc_write_q    <= 1'b1;
            sel_vector_q  <= 1'b1;
            state_q       <= REDIRECT;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        REDIRECT: begin
          pc_write_q   <= 1'b0;
          sel_vector_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Flag an illegal memory latency during simulation
  always_ff @(posedge clk) begin
    assert (MEM_LATENCY >= 1 && MEM_LATENCY <= 15)
      else $error("exception_vector_fetch: MEM_LATENCY=%0d outside 1..15", MEM_LATENCY);
  end

  assign mem_addr    = mem_addr_q;
  assign mem_read    = mem_read_q;
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign vector_byte = vector_byte_q;
  assign sel_vector  = sel_vector_q;
  assign pc_write    = pc_write_q;
  assign busy        = busy_q;

endmodule
